// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler for the register file: round-robin arbitration between EXU (A)
// and LSU (B) writebacks, a registered write stage, and a per-register busy scoreboard.
module rf_wb_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM     = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_valid,
  input  logic                   iss_wr,
  input  logic [REG_NUM_BIT-1:0] iss_rd,
  input  logic [REG_NUM_BIT-1:0] iss_rs1,
  input  logic [REG_NUM_BIT-1:0] iss_rs2,
  output logic                   iss_ready,
  input  logic                   wb_a_valid,
  input  logic [REG_NUM_BIT-1:0] wb_a_addr,
  input  logic [DATA_WIDTH-1:0]  wb_a_data,
  output logic                   wb_a_ready,
  input  logic                   wb_b_valid,
  input  logic [REG_NUM_BIT-1:0] wb_b_addr,
  input  logic [DATA_WIDTH-1:0]  wb_b_data,
  output logic                   wb_b_ready,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic [REG_NUM-1:0]     busy
);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  src_e                   rr_last_r;
  logic                   rf_wen_r;
  logic [REG_NUM_BIT-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0]  rf_wdata_r;
  logic [REG_NUM-1:0]     busy_r;
  logic [REG_NUM-1:0]     busy_nxt_s;
  logic                   grant_a_s;
  logic                   grant_b_s;
  logic                   win_s;
  logic                   win_wen_s;
  logic [REG_NUM_BIT-1:0] win_addr_s;
  logic [DATA_WIDTH-1:0]  win_data_s;
  logic                   iss_ready_s;

  // Round-robin grant: under contention the source that did not win last goes first
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({wb_a_valid, wb_b_valid})
      2'b10: grant_a_s = 1'b1;
      2'b01: grant_b_s = 1'b1;
      2'b11: begin
        if (rr_last_r == SRC_B) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Winner field mux; x0 writes complete the handshake but never enable the port
  always_comb begin
    win_s = grant_a_s | grant_b_s;
    if (grant_b_s) begin
      win_addr_s = wb_b_addr;
      win_data_s = wb_b_data;
    end else begin
      win_addr_s = wb_a_addr;
      win_data_s = wb_a_data;
    end
    win_wen_s = win_s && (win_addr_s != {REG_NUM_BIT{1'b0}});
  end

  // Issue hazard check against pending writes (RAW on sources, WAW on destination)
  always_comb begin
    iss_ready_s = !(busy_r[iss_rs1] | busy_r[iss_rs2] | (iss_wr & busy_r[iss_rd]));
  end

  // Scoreboard next state: clear on commit first, so a same-edge set wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (rf_wen_r) begin
      busy_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (iss_valid && iss_ready_s && iss_wr && (iss_rd != {REG_NUM_BIT{1'b0}})) begin
      busy_nxt_s[iss_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // State registers: arbiter history, write stage and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r  <= SRC_B;
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= {REG_NUM_BIT{1'b0}};
      rf_wdata_r <= {DATA_WIDTH{1'b0}};
      busy_r     <= {REG_NUM{1'b0}};
    end else begin
      if (grant_a_s) begin
        rr_last_r <= SRC_A;
      end else if (grant_b_s) begin
        rr_last_r <= SRC_B;
      end
      rf_wen_r <= win_wen_s;
      if (win_wen_s) begin
        rf_waddr_r <= win_addr_s;
        rf_wdata_r <= win_data_s;
      end
      busy_r <= busy_nxt_s;
    end
  end

  assign iss_ready  = iss_ready_s;
  assign wb_a_ready = grant_a_s;
  assign wb_b_ready = grant_b_s;
  assign rf_wen     = rf_wen_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbiter and scoreboard.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_wr, iss_ready;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        wb_a_valid, wb_a_ready, wb_b_valid, wb_b_ready;
  logic [4:0]  wb_a_addr, wb_b_addr;
  logic [31:0] wb_a_data, wb_b_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.DATA_WIDTH(32), .REG_NUM(32), .REG_NUM_BIT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready),
    .wb_a_valid(wb_a_valid), .wb_a_addr(wb_a_addr), .wb_a_data(wb_a_data), .wb_a_ready(wb_a_ready),
    .wb_b_valid(wb_b_valid), .wb_b_addr(wb_b_addr), .wb_b_data(wb_b_data), .wb_b_ready(wb_b_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: pending-register set, who won last, and the in-flight write
  logic [31:0] m_busy;
  bit          m_last_b;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          g_a, g_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 32'd0;
    m_last_b = 1'b1;
    m_wen    = 1'b0;
    m_waddr  = 5'd0;
    m_wdata  = 32'd0;
    g_a      = 1'b0;
    g_b      = 1'b0;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    wb_a_valid = 1'b0; wb_a_addr = 5'd0; wb_a_data = 32'd0;
    wb_b_valid = 1'b0; wb_b_addr = 5'd0; wb_b_data = 32'd0;
  endtask

  // One clock: check handshakes mid-cycle, advance model at the edge, check outputs after
  task automatic cycle();
    logic exp_ready, ea, eb;
    #2;
    exp_ready = !(m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_wr && m_busy[iss_rd]));
    ea = wb_a_valid && (!wb_b_valid || m_last_b);
    eb = wb_b_valid && (!wb_a_valid || !m_last_b);
    check("iss_ready", 64'(iss_ready), 64'(exp_ready));
    check("wb_a_ready", 64'(wb_a_ready), 64'(ea));
    check("wb_b_ready", 64'(wb_b_ready), 64'(eb));
    @(posedge clk);
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (iss_valid && exp_ready && iss_wr && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (ea || eb) m_last_b = eb;
    if (ea && wb_a_addr != 5'd0) begin
      m_wen = 1'b1; m_waddr = wb_a_addr; m_wdata = wb_a_data;
    end else if (eb && wb_b_addr != 5'd0) begin
      m_wen = 1'b1; m_waddr = wb_b_addr; m_wdata = wb_b_data;
    end else begin
      m_wen = 1'b0;
    end
    g_a = ea;
    g_b = eb;
    #1;
    check("rf_wen", 64'(rf_wen), 64'(m_wen));
    check("busy", 64'(busy), 64'(m_busy));
    if (m_wen) begin
      check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int seq [4] = '{1, 2, 1, 2};

  initial begin
    // 1: reset held with an EXU request pending has no effect on the write port
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    wb_a_valid = 1'b1; wb_a_addr = 5'd3; wb_a_data = 32'hCAFE0003;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_wen", 64'(rf_wen), 64'd0);
    check("rst_hold_busy", 64'(busy), 64'd0);
    wb_a_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_idle_waddr", 64'(rf_waddr), 64'd0);
    check("rst_idle_wdata", 64'(rf_wdata), 64'd0);
    check("rst_idle_wen", 64'(rf_wen), 64'd0);
    cycle();

    // 2: RAW stall on x5 until its writeback commits
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd5;
    cycle();
    check("busy5_set", 64'(busy[5]), 64'd1);
    iss_rd = 5'd6; iss_rs1 = 5'd5;
    #1 check("raw_stall", 64'(iss_ready), 64'd0);
    cycle();
    wb_a_valid = 1'b1; wb_a_addr = 5'd5; wb_a_data = 32'hDEADBEEF;
    cycle();
    check("wb5_wen", 64'(rf_wen), 64'd1);
    check("wb5_data", 64'(rf_wdata), 64'hDEADBEEF);
    wb_a_valid = 1'b0;
    cycle();
    check("busy5_clear", 64'(busy[5]), 64'd0);
    #1 check("raw_release", 64'(iss_ready), 64'd1);
    cycle();
    idle_inputs();
    cycle();

    // 3: contention alternates A,B,A,B starting with A after reset
    do_reset();
    wb_a_valid = 1'b1; wb_a_addr = 5'd1; wb_a_data = 32'h11111111;
    wb_b_valid = 1'b1; wb_b_addr = 5'd2; wb_b_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_seq_addr", 64'(rf_waddr), 64'(seq[i]));
    end
    idle_inputs();
    cycle();

    // 4: x0 writeback handshakes but never writes
    wb_a_valid = 1'b1; wb_a_addr = 5'd0; wb_a_data = 32'h00001234;
    #1 check("x0_ready", 64'(wb_a_ready), 64'd1);
    cycle();
    check("x0_wen", 64'(rf_wen), 64'd0);
    check("x0_busy", 64'(busy[0]), 64'd0);
    idle_inputs();

    // 5: commit to x7 and a new x7 issue on the same edge leave x7 busy
    wb_a_valid = 1'b1; wb_a_addr = 5'd7; wb_a_data = 32'h77777777;
    cycle();
    idle_inputs();
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd7;
    cycle();
    check("set_wins_busy7", 64'(busy[7]), 64'd1);
    idle_inputs();
    cycle();

    // 6: reset during an in-flight write to x3 discards it immediately
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd3;
    cycle();
    idle_inputs();
    wb_a_valid = 1'b1; wb_a_addr = 5'd3; wb_a_data = 32'h33333333;
    cycle();
    check("pre_rst_wen", 64'(rf_wen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wen", 64'(rf_wen), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    do_reset();

    // Random traffic: sources hold their request until granted
    for (int n = 0; n < 400; n++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr    = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      if (!wb_a_valid || g_a) begin
        wb_a_valid = ($urandom_range(0, 9) < 6);
        wb_a_addr  = 5'($urandom_range(0, 7));
        wb_a_data  = 32'($urandom);
      end
      if (!wb_b_valid || g_b) begin
        wb_b_valid = ($urandom_range(0, 9) < 6);
        wb_b_addr  = 5'($urandom_range(0, 7));
        wb_b_data  = 32'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
